// File: rtl/dec_rr_arbiter.sv
//------------------------------------------------------------------------------
// dec_rr_arbiter : round-robin arbiter, 16 requesters, index + one-hot grant.
// Optional forced release after MAX_HOLD cycles with `define DEC_ARB_TIMEOUT_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dec_rr_arbiter #(
  parameter int MAX_HOLD = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] grant,
  output logic [3:0]  gnt_idx,
  output logic        gnt_valid,
  output logic        timeout
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]  r_state;
  logic [3:0]  r_ptr;
  logic [15:0] r_grant;
  logic [3:0]  r_idx;
  logic        r_valid;

  logic [31:0] w_dbl;
  logic [15:0] w_rot;
  logic [3:0]  w_off;
  logic [3:0]  w_win_idx;
  logic [15:0] w_dec;
  logic        w_any_req;
  logic        w_norm_release;
  logic        w_force;
  logic        w_release;

  // Rotate requests so that bit 0 is the requester at the pointer; the
  // lowest set bit of the rotated vector is then the offset of the winner.
  assign w_dbl     = {req, req} >> r_ptr;
  assign w_rot     = w_dbl[15:0];
  assign w_any_req = |req;

  always_comb begin
    w_off = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = 4'(k);
      end
    end
  end

  assign w_win_idx = r_ptr + w_off;

  generate
    for (genvar n = 0; n < 16; n++) begin : g_dec
      assign w_dec[n] = (w_win_idx == 4'(n));
    end
  endgenerate

  assign w_norm_release = done | ~req[r_idx];
  assign w_release      = w_norm_release | w_force;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= 4'd0;
      r_grant <= 16'd0;
      r_idx   <= 4'd0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state <= ST_BUSY;
            r_grant <= w_dec;
            r_idx   <= w_win_idx;
            r_valid <= 1'b1;
          end
        end
        ST_BUSY: begin
          // gnt_idx deliberately keeps the last owner after release
          if (w_release) begin
            r_state <= ST_IDLE;
            r_grant <= 16'd0;
            r_valid <= 1'b0;
            r_ptr   <= r_idx + 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef DEC_ARB_TIMEOUT_EN
  localparam logic [7:0] C_HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] r_hold;
  logic       r_timeout;

  // A normal release in the same cycle wins, so the force term excludes it.
  assign w_force = (r_state == ST_BUSY) && !w_norm_release && (r_hold == C_HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold    <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_force;
      if (r_state == ST_IDLE || w_release) begin
        r_hold <= 8'd0;
      end else begin
        r_hold <= r_hold + 8'd1;
      end
    end
  end

  assign timeout = r_timeout;
`else
  localparam int c_unused_max_hold = MAX_HOLD;

  assign w_force = 1'b0;
  assign timeout = 1'b0;
`endif

  assign grant     = r_grant;
  assign gnt_idx   = r_idx;
  assign gnt_valid = r_valid;

endmodule

`default_nettype wire
